gol_matrix_scan: RTL and testbench

Downstream consumer of the Game-of-Life generation core's 64-bit grid. It double-buffers each new generation and row-scans it onto an 8x8 LED matrix, one row at a time with anti-ghosting blanking. It paces the simulation by pulsing a step request to the generation core every FRAMES_PER_GEN complete frames, and reports the live-cell population.

---
 rtl/gol_matrix_scan.sv | 133 +++++++++++++
 tb/tb_gol_matrix_scan.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_matrix_scan.sv
// gol_matrix_scan: double-buffers Game-of-Life generations and row-scans them
// onto an 8x8 LED matrix with a one-cycle blanking gap between rows. It also
// paces the generation core with step_req and reports the displayed population.
module gol_matrix_scan #(
    parameter int CLK_DIV        = 1000,
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic        clk,
    input  logic        start_n,
    input  logic [63:0] grid_in,
    input  logic        grid_valid,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic        step_req,
    output logic [6:0]  alive_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FC_W  = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRELAST = DIV_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
    localparam logic [FC_W-1:0]  FC_LAST     = FC_W'(FRAMES_PER_GEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SCAN  = 2'd2
    } state_t;

    state_t           state;
    logic [63:0]      pending;
    logic [63:0]      shadow;
    logic             pend_flag;
    logic [2:0]       row;
    logic [DIV_W-1:0] div;
    logic [FC_W-1:0]  frame_cnt;

    logic             row_end;
    logic             frame_end;
    logic             next_is_frame_end;
    logic [7:0]       next_row_sel;
    logic [7:0]       next_col;
    logic [6:0]       pop;

    // Row/frame timing decodes; frame_done is registered, so the final cycle
    // of row 7 is predicted one cycle ahead (from BLANK when CLK_DIV is 1).
    always_comb begin
        row_end           = (state == SCAN) && (div == DIV_LAST);
        frame_end         = row_end && (row == 3'd7);
        next_is_frame_end = (row == 3'd7) &&
                            (((state == BLANK) && (CLK_DIV == 1)) ||
                             ((state == SCAN) && (CLK_DIV > 1) && (div == DIV_PRELAST)));
        next_row_sel      = 8'd1 << row;
        next_col          = shadow[{~row, 3'b000} +: 8];
    end

    // Population count of the displayed grid.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            pop = pop + {6'd0, shadow[i]};
        end
    end

    // Scan FSM, double buffering, frame pacing and registered outputs.
    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            state       <= IDLE;
            pending     <= '0;
            shadow      <= '0;
            pend_flag   <= 1'b0;
            row         <= '0;
            div         <= '0;
            frame_cnt   <= '0;
            row_sel     <= '0;
            col_data    <= '0;
            frame_done  <= 1'b0;
            step_req    <= 1'b0;
            alive_count <= '0;
        end else begin
            frame_done  <= next_is_frame_end;
            step_req    <= next_is_frame_end && (frame_cnt == FC_LAST);
            alive_count <= pop;

            case (state)
                IDLE: begin
                    row_sel  <= '0;
                    col_data <= '0;
                    if (grid_valid) begin
                        shadow <= grid_in;
                        row    <= '0;
                        div    <= '0;
                        state  <= BLANK;
                    end
                end
                BLANK: begin
                    row_sel  <= next_row_sel;
                    col_data <= next_col;
                    div      <= '0;
                    state    <= SCAN;
                end
                SCAN: begin
                    if (row_end) begin
                        row_sel  <= '0;
                        col_data <= '0;
                        row      <= row + 3'd1;
                        state    <= BLANK;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // New generations wait in pending until the frame boundary, where
            // a coincident grid_valid takes priority over the stale pending copy.
            if (frame_end) begin
                if (grid_valid) begin
                    shadow <= grid_in;
                end else if (pend_flag) begin
                    shadow <= pending;
                end
                pend_flag <= 1'b0;
                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
            end else if ((state != IDLE) && grid_valid) begin
                pending   <= grid_in;
                pend_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gol_matrix_scan.sv
// Self-checking bench for gol_matrix_scan using a frame-arithmetic reference model.
module tb_gol_matrix_scan;

    localparam int CD    = 4;
    localparam int FPG   = 2;
    localparam int FRAME = 8 * (CD + 1);

    logic        clk;
    logic        start_n;
    logic [63:0] grid_in;
    logic        grid_valid;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic        step_req;
    logic [6:0]  alive_count;

    gol_matrix_scan #(
        .CLK_DIV        (CD),
        .FRAMES_PER_GEN (FPG)
    ) dut (
        .clk         (clk),
        .start_n     (start_n),
        .grid_in     (grid_in),
        .grid_valid  (grid_valid),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_done  (frame_done),
        .step_req    (step_req),
        .alive_count (alive_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: display timing is pure arithmetic on the cycle index
    // relative to the grid_valid that left IDLE.
    int          cyc = 0;
    logic        running = 1'b0;
    int          t0 = 0;
    logic [63:0] disp = '0;
    logic [63:0] pend = '0;
    logic        pflag = 1'b0;
    int          alive_exp = 0;
    logic [24:0] exp_v;

    localparam logic [63:0] GLIDER = 64'h4020_E000_0000_0000;

    function automatic logic [24:0] observed();
        return {row_sel, col_data, frame_done, step_req, alive_count};
    endfunction

    function automatic int upcoming_phase();
        return running ? ((cyc - t0) % FRAME) : -1;
    endfunction

    task automatic model_reset();
        running   = 1'b0;
        disp      = '0;
        pend      = '0;
        pflag     = 1'b0;
        alive_exp = 0;
    endtask

    // Advance one cycle: drive inputs, compute expectation, update model,
    // return at the following negedge with exp_v valid for this cycle.
    task automatic step(input logic gv, input logic [63:0] gin);
        int p;
        int r;
        logic [7:0] rs;
        logic [7:0] cd;
        logic fd;
        logic sr;
        @(posedge clk);
        #1;
        grid_valid = gv;
        grid_in    = gin;
        cyc++;
        p  = -1;
        rs = '0;
        cd = '0;
        fd = 1'b0;
        sr = 1'b0;
        if (running) begin
            p = (cyc - t0 - 1) % FRAME;
            if ((p % (CD + 1)) != 0) begin
                r  = p / (CD + 1);
                rs = 8'd1 << r;
                cd = 8'((disp >> (56 - 8 * r)) & 64'hFF);
            end
            fd = (p == FRAME - 1);
            sr = fd && ((((cyc - t0 - 1) / FRAME) + 1) % FPG == 0);
        end
        exp_v = {rs, cd, fd, sr, 7'(alive_exp)};
        alive_exp = $countones(disp);
        if (!running) begin
            if (gv) begin
                running = 1'b1;
                t0      = cyc;
                disp    = gin;
            end
        end else if (p == FRAME - 1) begin
            if (gv) disp = gin;
            else if (pflag) disp = pend;
            pflag = 1'b0;
        end else if (gv) begin
            pend  = gin;
            pflag = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic advance_to(input int target);
        for (int k = 0; k < 2 * FRAME && upcoming_phase() != target; k++) begin
            step(1'b0, '0);
        end
    endtask

    task automatic test_reset();
        start_n    = 1'b1;
        grid_valid = 1'b0;
        grid_in    = '0;
        #2 start_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (observed() !== 25'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", observed(), 25'd0);
        end
        #2 start_n = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b0, {$urandom, $urandom});
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL idle_cycle%0d: got %h expected %h", i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_glider();
        step(1'b1, GLIDER);
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL glider_start: got %h expected %h", observed(), exp_v);
        end
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            step(1'b0, '0);
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL glider_cycle%0d: got %h expected %h", i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_mid_frame();
        advance_to(3 * (CD + 1) + 2);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(i == 0, (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL mid_frame_cycle%0d: got %h expected %h", i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        logic [63:0] b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        advance_to(10);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(i == 0 || i == 2, (i == 0) ? a : b);
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL back_to_back_cycle%0d: got %h expected %h", i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_coincident();
        logic [63:0] stale;
        logic [63:0] fresh;
        stale = {$urandom, $urandom};
        fresh = {$urandom, $urandom};
        advance_to(20);
        step(1'b1, stale);
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL coincident_pend: got %h expected %h", observed(), exp_v);
        end
        advance_to(FRAME - 1);
        for (int i = 0; i < FRAME + 5; i++) begin
            step(i == 0, fresh);
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL coincident_cycle%0d: got %h expected %h", i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic gv;
        for (int i = 0; i < 600; i++) begin
            if (upcoming_phase() == FRAME - 1) gv = ($urandom % 2) == 0;
            else gv = ($urandom % 12) == 0;
            step(gv, {$urandom, $urandom});
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        advance_to(5 * (CD + 1) + 2);
        step(1'b0, '0);
        #2 start_n = 1'b0;
        #1;
        checks++;
        if ({row_sel, col_data} !== 16'd0) begin
            errors++;
            $display("FAIL async_blank: got %h expected %h", {row_sel, col_data}, 16'd0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #2 start_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, {$urandom, $urandom});
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL post_reset_idle%0d: got %h expected %h", i, observed(), exp_v);
            end
        end
        for (int i = 0; i < FRAME + 5; i++) begin
            step(i == 0, GLIDER);
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL restart_cycle%0d: got %h expected %h", i, observed(), exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glider();
        test_mid_frame();
        test_back_to_back();
        test_coincident();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
